// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory controller turning MemRead/MemWrite into a req/rdy access with pipeline stall.
// Define MEM_LOAD_BYPASS_EN to add a one-entry last-load buffer that completes repeat loads without a memory access.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] EX_MEM_ALU_out,
    input  logic [DATA_W-1:0] EX_MEM_reg2_data,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic [DATA_W-1:0] MemData,
    output logic              mem_stall,
    output logic              mem_timeout,
    output logic              access_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [7:0] cnt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] hit_data;
    logic hit, start, expired;

    assign expired = !mem_rdy && cnt == 8'(TIMEOUT_CYCLES - 1);
    assign start = state == IDLE && (EX_MEM_MemRead || EX_MEM_MemWrite) && !hit;
    // Gated by rst_n so the pipeline is never frozen while reset is held.
    assign mem_stall = rst_n && (state == BUSY || start);
    assign MemData = hit ? hit_data : data_q;

`ifdef MEM_LOAD_BYPASS_EN
    logic buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    assign hit = state == IDLE && buf_valid && EX_MEM_MemRead && !EX_MEM_MemWrite && EX_MEM_ALU_out == buf_addr;
    assign hit_data = buf_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (start && EX_MEM_MemWrite && EX_MEM_ALU_out == buf_addr) begin
            buf_valid <= 1'b0;
        end else if (state == BUSY && mem_rdy && !mem_we) begin
            buf_valid <= 1'b1;
            buf_addr <= mem_addr;
            buf_data <= mem_rdata;
        end else if (state == BUSY && expired) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            data_q <= '0;
            mem_timeout <= 1'b0;
            access_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_req <= 1'b1;
                        mem_we <= EX_MEM_MemWrite;
                        mem_addr <= EX_MEM_ALU_out;
                        mem_wdata <= EX_MEM_reg2_data;
                        cnt <= '0;
                        access_err <= access_err || (EX_MEM_MemRead && EX_MEM_MemWrite);
                        state <= BUSY;
                    end else if (hit) begin
                        data_q <= hit_data;
                    end
                end
                BUSY: begin
                    if (mem_rdy) begin
                        mem_req <= 1'b0;
                        if (!mem_we) data_q <= mem_rdata;
                        state <= DONE;
                    end else if (expired) begin
                        mem_req <= 1'b0;
                        mem_timeout <= 1'b1;
                        if (!mem_we) data_q <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed accesses against a transaction-level model of the memory controller.
module tb_mem_access_ctrl;
    localparam int TO = 15;
`ifdef MEM_LOAD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] alu, wd, rdata;
    logic rd, wr, rdy;
    logic mem_req, mem_we, mem_stall, mem_timeout, access_err;
    logic [15:0] mem_addr, mem_wdata, MemData;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_MEM_ALU_out(alu), .EX_MEM_reg2_data(wd),
        .EX_MEM_MemRead(rd), .EX_MEM_MemWrite(wr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(rdata), .mem_rdy(rdy),
        .MemData(MemData), .mem_stall(mem_stall),
        .mem_timeout(mem_timeout), .access_err(access_err)
    );

    int vecs = 0;
    int errs = 0;
    bit chk_on = 1'b0;
    logic exp_stall, exp_req, exp_we, exp_to, exp_err;
    logic [15:0] exp_addr, exp_wd, md;
    bit bv;
    logic [15:0] ba, bd;
    int req_n, stall_n;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall", 32'(mem_stall), 32'(exp_stall));
            chk("req", 32'(mem_req), 32'(exp_req));
            chk("MemData", 32'(MemData), 32'(md));
            chk("timeout", 32'(mem_timeout), 32'(exp_to));
            chk("access_err", 32'(access_err), 32'(exp_err));
            if (exp_req) begin
                chk("we", 32'(mem_we), 32'(exp_we));
                chk("addr", 32'(mem_addr), 32'(exp_addr));
                chk("wdata", 32'(mem_wdata), 32'(exp_wd));
            end
            req_n += int'(mem_req);
            stall_n += int'(mem_stall);
        end
    end

    // rdy_at: BUSY cycle (1-based) on which memory answers; 0 = never answers.
    task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input int rdy_at, input logic [15:0] rdat);
        bit hit;
        int l;
        hit = BYP && bv && r && !w && a == ba;
        l = (rdy_at == 0) ? TO : rdy_at;
        req_n = 0;
        stall_n = 0;
        @(posedge clk); #1;
        rd = r; wr = w; alu = a; wd = d; rdy = 1'b0;
        if (hit) begin
            exp_stall = 1'b0;
            exp_req = 1'b0;
            md = bd;
        end else begin
            exp_stall = 1'b1;
            exp_req = 1'b0;
            for (int i = 1; i <= l; i++) begin
                @(posedge clk); #1;
                if (i == 1) begin
                    exp_req = 1'b1;
                    exp_we = w;
                    exp_addr = a;
                    exp_wd = d;
                    if (r && w) exp_err = 1'b1;
                    if (w && a == ba) bv = 1'b0;
                end
                rdy = (i == rdy_at);
                rdata = (i == rdy_at) ? rdat : 16'hDEAD;
            end
            @(posedge clk); #1;
            rdy = 1'b0;
            exp_stall = 1'b0;
            exp_req = 1'b0;
            if (rdy_at == 0) begin
                exp_to = 1'b1;
                bv = 1'b0;
                if (!w) md = 16'h0000;
            end else if (!w) begin
                md = rdat;
                bv = 1'b1;
                ba = a;
                bd = rdat;
            end
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        exp_stall = 1'b0;
        exp_req = 1'b0;
    endtask

    initial begin
        rd = 1'b1; wr = 1'b0; alu = '0; wd = '0; rdata = '0; rdy = 1'b0;
        exp_stall = 0; exp_req = 0; exp_we = 0; exp_to = 0; exp_err = 0;
        exp_addr = '0; exp_wd = '0; md = '0; bv = 0; ba = '0; bd = '0;
        #12;
        chk("reset stall", 32'(mem_stall), 32'd0);
        chk("reset req", 32'(mem_req), 32'd0);
        chk("reset MemData", 32'(MemData), 32'd0);
        chk("reset addr", 32'(mem_addr), 32'd0);
        chk("reset flags", 32'({mem_timeout, access_err, mem_we}), 32'd0);
        rd = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk_on = 1'b1;

        access(1, 0, 16'h0040, 16'h0000, 3, 16'hBEEF);
        chk("load req cycles", 32'(req_n), 32'd3);
        chk("load stall cycles", 32'(stall_n), 32'd4);
        chk("load MemData", 32'(MemData), 32'h0000BEEF);

        access(0, 1, 16'h0010, 16'h1234, 1, 16'h0000);
        chk("store req cycles", 32'(req_n), 32'd1);
        chk("store stall cycles", 32'(stall_n), 32'd2);
        chk("store MemData kept", 32'(MemData), 32'h0000BEEF);

        access(1, 0, 16'h0050, 16'h0000, 0, 16'h0000);
        chk("timeout req cycles", 32'(req_n), 32'd15);
        chk("timeout flag", 32'(mem_timeout), 32'd1);
        chk("timeout MemData", 32'(MemData), 32'd0);

        access(1, 1, 16'h0020, 16'h5555, 2, 16'h0000);
        chk("both-high err", 32'(access_err), 32'd1);
        access(1, 0, 16'h0030, 16'h0000, 1, 16'hA5A5);
        chk("err sticky", 32'(access_err), 32'd1);

        // Stray rdy outside BUSY must be ignored.
        @(posedge clk); #1; rdy = 1'b1; rdata = 16'hFFFF;
        @(posedge clk); #1; rdy = 1'b0;

        // Reset during the second BUSY cycle of a load.
        @(posedge clk); #1; rd = 1'b1; alu = 16'h0060; exp_stall = 1'b1;
        @(posedge clk); #1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 16'h0060; exp_wd = wd;
        @(posedge clk); #1; chk_on = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst req", 32'(mem_req), 32'd0);
        chk("rst stall", 32'(mem_stall), 32'd0);
        chk("rst MemData", 32'(MemData), 32'd0);
        rd = 1'b0;
        @(negedge clk); #1; rst_n = 1'b1;
        md = '0; exp_to = 0; exp_err = 0; exp_stall = 0; exp_req = 0; bv = 0;
        chk_on = 1'b1;

        access(1, 0, 16'h0040, 16'h0000, 2, 16'hBEEF);
        chk("post-reset load", 32'(MemData), 32'h0000BEEF);
        access(1, 0, 16'h0040, 16'h0000, 1, 16'h1111);
        chk("repeat load req cycles", 32'(req_n), BYP ? 32'd0 : 32'd1);
        chk("repeat load MemData", 32'(MemData), BYP ? 32'h0000BEEF : 32'h00001111);
        access(0, 1, 16'h0040, 16'h7777, 1, 16'h0000);
        access(1, 0, 16'h0040, 16'h0000, 2, 16'h2222);
        chk("load after store req cycles", 32'(req_n), 32'd2);
        chk("load after store MemData", 32'(MemData), 32'h00002222);

        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
